// File: rtl/mdu_pkg.sv
// mdu_pkg: shared definitions for the EX-stage multiply/divide unit.
//   - op encodings (MDU_NOP..MDU_MADD)
//   - FSM state type and constants
//   - DIV_LAT and the default MUL_STAGES
//   - abs helper used for divider sign pre-correction
package mdu_pkg;
  localparam logic [2:0] MDU_NOP   = 3'd0;
  localparam logic [2:0] MDU_MULT  = 3'd1;
  localparam logic [2:0] MDU_MULTU = 3'd2;
  localparam logic [2:0] MDU_DIV   = 3'd3;
  localparam logic [2:0] MDU_DIVU  = 3'd4;
  localparam logic [2:0] MDU_MTHI  = 3'd5;
  localparam logic [2:0] MDU_MTLO  = 3'd6;
  localparam logic [2:0] MDU_MADD  = 3'd7;

  typedef logic [1:0] mdu_state_t;
  localparam mdu_state_t ST_IDLE = 2'd0;
  localparam mdu_state_t ST_MUL  = 2'd1;
  localparam mdu_state_t ST_DIV  = 2'd2;

  // 32 restoring iterations + 1 sign-fix cycle
  localparam int DIV_LAT        = 33;
  localparam int MUL_STAGES_DEF = 2;

  // Magnitude of v when treated as signed (sgn=1); pass-through otherwise.
  function automatic logic [31:0] abs32(input logic [31:0] v, input logic sgn);
    return (sgn && v[31]) ? (32'd0 - v) : v;
  endfunction
endpackage

// File: rtl/mdu_divider.sv
// mdu_divider: iterative restoring 32-bit divider.
//   Operands are converted to magnitudes at start, 32 unsigned iterations
//   run one per cycle, then quotient/remainder are sign-corrected
//   combinationally during the final (done) cycle.
//   Divide by zero overrides the result: quotient=all ones, remainder=a.
// Ports:
//   clk, rst      clock, synchronous active-high reset
//   start         latch a/b and begin (one cycle)
//   a, b          dividend, divisor
//   signed_op     1 = signed divide
//   flush         abort in-flight divide
//   done          high during the cycle results are valid
//   quotient, remainder  results (valid while done)
module mdu_divider
  import mdu_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic        signed_op,
  input  logic        flush,
  output logic        done,
  output logic [31:0] quotient,
  output logic [31:0] remainder
);
  localparam logic [5:0] LAST = 6'(DIV_LAT - 1);

  logic        run;
  logic [5:0]  cnt;
  logic [31:0] rem, quo, dvs, a_q;
  logic        neg_q, neg_r, bz;
  logic [32:0] r_sh, diff;

  // Shift next dividend bit into the partial remainder, trial-subtract.
  assign r_sh = {rem, quo[31]};
  assign diff = r_sh - {1'b0, dvs};

  always_ff @(posedge clk) begin
    if (rst || flush) begin
      run   <= 1'b0;
      cnt   <= '0;
      rem   <= '0;
      quo   <= '0;
      dvs   <= '0;
      a_q   <= '0;
      neg_q <= 1'b0;
      neg_r <= 1'b0;
      bz    <= 1'b0;
    end else if (start) begin
      run   <= 1'b1;
      cnt   <= '0;
      rem   <= '0;
      quo   <= abs32(a, signed_op);
      dvs   <= abs32(b, signed_op);
      a_q   <= a;
      neg_q <= signed_op & (a[31] ^ b[31]);
      neg_r <= signed_op & a[31];
      bz    <= (b == 32'd0);
    end else if (run) begin
      if (cnt == LAST) begin
        run <= 1'b0;
      end else begin
        cnt <= cnt + 6'd1;
        if (!diff[32]) begin
          rem <= diff[31:0];
          quo <= {quo[30:0], 1'b1};
        end else begin
          rem <= r_sh[31:0];
          quo <= {quo[30:0], 1'b0};
        end
      end
    end
  end

  assign done      = run && (cnt == LAST);
  // 0x80000000 / -1 falls out naturally: magnitude quotient 0x80000000, no negation.
  assign quotient  = bz ? 32'hFFFF_FFFF : (neg_q ? (32'd0 - quo) : quo);
  assign remainder = bz ? a_q : (neg_r ? (32'd0 - rem) : rem);
endmodule

// File: rtl/ex_muldiv_unit.sv
// ex_muldiv_unit: EX-stage multiply/divide unit owning HI/LO.
//   Operands come from the post-forwarding EX muxes. MUL completes
//   MUL_STAGES cycles after the start edge, DIV after DIV_LAT cycles.
//   Any op (or MFHI/MFLO) arriving while busy raises stall_req.
//   Build option: MDU_MADD_EN enables op 7 = signed MADD
//   ({hi,lo} += opa*opb, latency MUL_STAGES+1); otherwise op 7 is a NOP.
// Ports:
//   clk, rst        clock, synchronous active-high reset
//   start, op       valid MDU op in EX and its encoding
//   opa, opb        forwarded rs / rt values
//   rd_req          MFHI/MFLO in EX
//   flush           EX squash; beats start and cancels in-flight ops
//   hi, lo          architectural HI/LO
//   busy            multi-cycle op in flight
//   done            pulse after HI/LO take a MUL/DIV result
//   stall_req       busy & (start | rd_req)
module ex_muldiv_unit
  import mdu_pkg::*;
#(
  parameter int MUL_STAGES = MUL_STAGES_DEF
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [2:0]  op,
  input  logic [31:0] opa,
  input  logic [31:0] opb,
  input  logic        rd_req,
  input  logic        flush,
  output logic [31:0] hi,
  output logic [31:0] lo,
  output logic        busy,
  output logic        done,
  output logic        stall_req
);
  mdu_state_t         state;
  logic [2:0]         cnt;
  logic signed [32:0] ma, mb;
  logic signed [65:0] prod;
  logic [63:0]        mul_res;
  logic               div_start, div_done;
  logic [31:0]        div_q, div_r;
  logic               idle_go;

  assign idle_go   = (state == ST_IDLE) && start && !flush;
  assign div_start = idle_go && ((op == MDU_DIV) || (op == MDU_DIVU));

  // Operands are held in ma/mb for the whole op, so the product only
  // depends on what was latched at the start edge.
  assign prod = ma * mb;

`ifdef MDU_MADD_EN
  logic madd;
  assign mul_res = madd ? ({hi, lo} + prod[63:0]) : prod[63:0];
`else
  assign mul_res = prod[63:0];
`endif

  mdu_divider u_div (
    .clk       (clk),
    .rst       (rst),
    .start     (div_start),
    .a         (opa),
    .b         (opb),
    .signed_op (op == MDU_DIV),
    .flush     (flush),
    .done      (div_done),
    .quotient  (div_q),
    .remainder (div_r)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= ST_IDLE;
      cnt   <= '0;
      hi    <= '0;
      lo    <= '0;
      done  <= 1'b0;
      ma    <= '0;
      mb    <= '0;
`ifdef MDU_MADD_EN
      madd  <= 1'b0;
`endif
    end else begin
      done <= 1'b0;
      case (state)
        ST_IDLE: if (idle_go) begin
          case (op)
            MDU_MULT, MDU_MULTU: begin
              ma    <= {(op == MDU_MULT) & opa[31], opa};
              mb    <= {(op == MDU_MULT) & opb[31], opb};
              cnt   <= 3'(MUL_STAGES - 1);
              state <= ST_MUL;
`ifdef MDU_MADD_EN
              madd  <= 1'b0;
`endif
            end
`ifdef MDU_MADD_EN
            MDU_MADD: begin
              ma    <= {opa[31], opa};
              mb    <= {opb[31], opb};
              cnt   <= 3'(MUL_STAGES);
              state <= ST_MUL;
              madd  <= 1'b1;
            end
`endif
            MDU_DIV, MDU_DIVU: state <= ST_DIV;
            MDU_MTHI: hi <= opa;
            MDU_MTLO: lo <= opa;
            default: ;
          endcase
        end
        ST_MUL: begin
          if (flush) begin
            state <= ST_IDLE;
          end else if (cnt == 3'd0) begin
            {hi, lo} <= mul_res;
            done     <= 1'b1;
            state    <= ST_IDLE;
          end else begin
            cnt <= cnt - 3'd1;
          end
        end
        ST_DIV: begin
          if (flush) begin
            state <= ST_IDLE;
          end else if (div_done) begin
            hi    <= div_r;
            lo    <= div_q;
            done  <= 1'b1;
            state <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign busy      = (state != ST_IDLE);
  assign stall_req = busy & (start | rd_req);
endmodule
